// File: rtl/dem14_dispatch_ctrl.sv
// dem14_dispatch_ctrl
// Single-producer to four-consumer dispatcher. Each accepted beat is steered
// into one registered output slot, chosen either round-robin (skipping busy
// slots) or by a fixed select. Each slot is a one-deep register with its own
// valid/ready handshake and a saturating count of beats it has accepted.
module dem14_dispatch_ctrl #(
  parameter int DW    = 8,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic              mode,
  input  logic [1:0]        fix_sel,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [4*DW-1:0]   out_data,
  output logic [1:0]        cur_sel,
  output logic [4*CNT_W-1:0] cnt_ch
);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  slot_e            slot_q [4];
  slot_e            slot_d [4];
  logic [DW-1:0]    data_q [4];
  logic [DW-1:0]    data_d [4];
  logic [CNT_W-1:0] cnt_q  [4];
  logic [CNT_W-1:0] cnt_d  [4];
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       cur_q, cur_d;

  logic [3:0]       free;
  logic [1:0]       target;
  logic [1:0]       cand;
  logic             accept;

  // A slot can take a beat if it is empty or being drained this same cycle.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      free[k] = (slot_q[k] == SLOT_EMPTY) | out_ready[k];
    end
  end

  // Target selection and input-side ready; ready is forced low during reset.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    target   = fix_sel;
    in_ready = 1'b0;
    cand     = ptr_q;
    if (mode) begin
      in_ready = free[fix_sel];
    end else begin
      in_ready = |free;
      target   = ptr_q;
      // Walk from the farthest candidate back to ptr so the nearest free slot wins.
      for (int i = 3; i >= 0; i--) begin
        cand = ptr_q + 2'(i);
        if (free[cand]) target = cand;
      end
    end
    if (!rst_n) in_ready = 1'b0;
  end

  assign accept = in_valid & in_ready;

  // Next-state for slots, data, counters, RR pointer and last-target register.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      slot_d[k] = slot_q[k];
      data_d[k] = data_q[k];
      cnt_d[k]  = cnt_q[k];
      if (slot_q[k] == SLOT_FULL && out_ready[k]) slot_d[k] = SLOT_EMPTY;
    end
    ptr_d = ptr_q;
    cur_d = cur_q;
    if (accept) begin
      // A same-cycle drain and accept leaves the slot FULL with the new beat.
      slot_d[target] = SLOT_FULL;
      data_d[target] = in_data;
      if (cnt_q[target] != {CNT_W{1'b1}}) cnt_d[target] = cnt_q[target] + CNT_W'(1);
      cur_d = target;
      if (!mode) ptr_d = target + 2'd1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        slot_q[k] <= SLOT_EMPTY;
        // NOTE: slot data is reset too, because out_data must read zero after reset.
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
      ptr_q <= 2'd0;
      cur_q <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      for (int k = 0; k < 4; k++) begin
        slot_q[k] <= slot_d[k];
        data_q[k] <= data_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
      ptr_q <= ptr_d;
      cur_q <= cur_d;
    end
  end

  // Flatten per-channel state onto the packed output buses.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      out_valid[k]                  = (slot_q[k] == SLOT_FULL);
      out_data[k*DW +: DW]          = data_q[k];
      cnt_ch[k*CNT_W +: CNT_W]      = cnt_q[k];
    end
  end

  assign cur_sel = cur_q;

endmodule
